// File: rtl/dac_pkg.sv
// Shared widths, DAC command/address codes, request record and scheduler
// state encoding for the dacspi port sharing logic.
package dac_pkg;

    localparam int DAC_DATA_W = 12;
    localparam int DAC_ADDR_W = 4;
    localparam int DAC_CMD_W  = 4;

    localparam logic [DAC_CMD_W-1:0] CMD_WRITE        = 4'b0000;
    localparam logic [DAC_CMD_W-1:0] CMD_UPDATE       = 4'b0001;
    localparam logic [DAC_CMD_W-1:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [DAC_CMD_W-1:0] CMD_PWRDN        = 4'b0100;

    localparam logic [DAC_ADDR_W-1:0] ADDR_A   = 4'd0;
    localparam logic [DAC_ADDR_W-1:0] ADDR_B   = 4'd1;
    localparam logic [DAC_ADDR_W-1:0] ADDR_C   = 4'd2;
    localparam logic [DAC_ADDR_W-1:0] ADDR_D   = 4'd3;
    localparam logic [DAC_ADDR_W-1:0] ADDR_ALL = 4'b1111;

    typedef struct packed {
        logic [DAC_DATA_W-1:0] data;
        logic [DAC_ADDR_W-1:0] addr;
        logic [DAC_CMD_W-1:0]  cmd;
    } dac_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// The pointer register lives with the caller.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    gnt_idx,
    output logic             any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dac_sched.sv
// Shares the dacspi transaction port between N_REQ requesters, each with a
// one-deep mailbox, serviced round-robin with a dacdone timeout.
module dac_sched
    import dac_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        CLK50MHZ,
    input  logic                        RST,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [DAC_DATA_W*N_REQ-1:0] req_data,
    input  logic [DAC_ADDR_W*N_REQ-1:0] req_addr,
    input  logic [DAC_CMD_W*N_REQ-1:0]  req_cmd,
    output logic [N_REQ-1:0]            req_pending,
    output logic [N_REQ-1:0]            req_ack,
    output logic [DAC_DATA_W-1:0]       data,
    output logic [DAC_ADDR_W-1:0]       address,
    output logic [DAC_CMD_W-1:0]        command,
    output logic                        dactrig,
    input  logic                        dacdone,
    output logic                        timeout_err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);

    dac_state_t             state_q, state_d;
    dac_req_t [N_REQ-1:0]   mbox;
    logic [N_REQ-1:0]       pending;
    logic [N_REQ-1:0]       gnt, grant_q;
    logic [PW-1:0]          gnt_idx, ptr_q;
    logic                   any_req;
    logic [CW-1:0]          cnt_q;
    logic                   take, done_ok, to_hit;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (pending),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // A write in the grant cycle wins over the clear: the frame takes the old
    // mailbox contents and the new write stays pending for a later frame.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            mbox    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_wr[i]) begin
                    mbox[i].data <= req_data[DAC_DATA_W*i +: DAC_DATA_W];
                    mbox[i].addr <= req_addr[DAC_ADDR_W*i +: DAC_ADDR_W];
                    mbox[i].cmd  <= req_cmd[DAC_CMD_W*i +: DAC_CMD_W];
                    pending[i]   <= 1'b1;
                end else if (take && gnt[i]) begin
                    pending[i]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        done_ok = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dacdone) begin
                    done_ok = 1'b1;
                    state_d = ST_GAP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    to_hit  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            data        <= '0;
            address     <= '0;
            command     <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (take) begin
                data    <= mbox[gnt_idx].data;
                address <= mbox[gnt_idx].addr;
                command <= mbox[gnt_idx].cmd;
                grant_q <= gnt;
                ptr_q   <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            cnt_q       <= (state_q == ST_ISSUE) ? cnt_q + 1'b1 : '0;
            req_ack     <= done_ok ? grant_q : '0;
            timeout_err <= timeout_err | to_hit;
        end
    end

    assign dactrig     = (state_q == ST_ISSUE);
    assign req_pending = pending;

endmodule

// File: tb/tb_dac_sched.sv
// Directed bench for dac_sched with a dacspi model that answers ~34 cycles
// after each dactrig rise; frames and acks are logged by a negedge monitor.
module tb_dac_sched;
    import dac_pkg::*;

    localparam int N  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_wr = '0;
    logic [12*N-1:0] req_data = '0;
    logic [4*N-1:0]  req_addr = '0;
    logic [4*N-1:0]  req_cmd = '0;
    logic [N-1:0]    req_pending, req_ack;
    logic [11:0]     data;
    logic [3:0]      address, command;
    logic            dactrig, dacdone, timeout_err;
    logic            model_done = 1'b0;
    logic            stray = 1'b0;
    logic            model_en = 1'b1;

    assign dacdone = model_done | stray;

    dac_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .CLK50MHZ    (clk),
        .RST         (rst),
        .req_wr      (req_wr),
        .req_data    (req_data),
        .req_addr    (req_addr),
        .req_cmd     (req_cmd),
        .req_pending (req_pending),
        .req_ack     (req_ack),
        .data        (data),
        .address     (address),
        .command     (command),
        .dactrig     (dactrig),
        .dacdone     (dacdone),
        .timeout_err (timeout_err)
    );

    always #10 clk = ~clk;

    // dacspi model
    logic m_prev = 1'b0;
    int   m_cnt  = 0;
    always @(negedge clk) begin
        m_prev     <= dactrig;
        model_done <= 1'b0;
        if (rst) m_cnt <= 0;
        else if (dactrig && !m_prev && model_en) m_cnt <= 34;
        else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) model_done <= 1'b1;
        end
    end

    // frame / ack monitor
    logic [19:0] frames[$];
    int          ack_cnt[N];
    logic        mon_prev = 1'b0;
    int          low_run = 0;
    int          min_gap = 1000;
    always @(negedge clk) begin
        mon_prev <= dactrig;
        if (dactrig && !mon_prev) begin
            frames.push_back({command, address, data});
            if (low_run < min_gap) min_gap <= low_run;
        end
        low_run <= dactrig ? 0 : low_run + 1;
        for (int i = 0; i < N; i++) ack_cnt[i] <= ack_cnt[i] + int'(req_ack[i]);
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int i, input logic [11:0] d, input logic [3:0] a, input logic [3:0] c);
        req_data[12*i +: 12] = d;
        req_addr[4*i +: 4]   = a;
        req_cmd[4*i +: 4]    = c;
        req_wr[i]            = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        req_wr = '0;
        stray  = 1'b0;
    endtask

    task automatic wait_trig(input logic lvl, input string tag);
        int k = 0;
        while (dactrig !== lvl && k < 200) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 200), 32'd1);
    endtask

    task automatic settle(input int n, input string tag);
        int k = 0;
        while (!(frames.size() >= n && !dactrig && req_pending == '0) && k < 2000) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk(tag, 32'(k < 2000), 32'd1);
    endtask

    logic [19:0] exp_frames [14] = '{
        20'h3F03F, 20'h00100, 20'h01101, 20'h02102, 20'h03103, 20'h00110, 20'h03113,
        20'h12222, 20'h01200, 20'h01300, 20'h330BB, 20'h310AA, 20'h00555, 20'h410CD
    };

    initial begin
        int found;
        int hi;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(dactrig), 0);
        chk("rst_data", 32'({command, address, data}), 0);
        chk("rst_pend_ack", 32'({req_pending, req_ack}), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // 1: single frame and its latency
        wr(0, 12'h03F, ADDR_ALL, CMD_WRITE_UPDATE);
        tick();
        chk("t1_pend", 32'(req_pending), 32'h1);
        chk("t1_trig_lo", 32'(dactrig), 0);
        tick();
        chk("t1_trig_hi", 32'(dactrig), 1);
        chk("t1_fields", 32'({command, address, data}), 32'h3F03F);
        chk("t1_pend_clr", 32'(req_pending), 0);
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            tick();
            if (req_ack[0]) found = 1;
        end
        chk("t1_ack_seen", 32'(found), 1);
        chk("t1_trig_off", 32'(dactrig), 0);
        tick();
        chk("t1_ack_pulse", 32'(req_ack), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 2: round robin from pointer 0, then refill 3 and 0
        for (int i = 0; i < N; i++) wr(i, 12'h100 + 12'(i), 4'(i), CMD_WRITE);
        tick();
        settle(5, "t2_batch_done");
        wr(3, 12'h113, ADDR_D, CMD_WRITE);
        wr(0, 12'h110, ADDR_A, CMD_WRITE);
        tick();
        settle(7, "t2_refill_done");
        chk("t2_ack0", 32'(ack_cnt[0]), 3);
        chk("t2_ack3", 32'(ack_cnt[3]), 2);

        // 3: overwrite while another slot busy, then rewrite during own frame
        wr(2, 12'h222, ADDR_C, CMD_UPDATE);
        tick();
        wait_trig(1'b1, "t3_f7_start");
        wr(1, 12'h100, ADDR_B, CMD_WRITE);
        tick();
        wr(1, 12'h200, ADDR_B, CMD_WRITE);
        tick();
        chk("t3_pend1", 32'(req_pending), 32'h2);
        chk("t3_hold", 32'(data), 32'h222);
        wait_trig(1'b0, "t3_f7_end");
        wait_trig(1'b1, "t3_f8_start");
        chk("t3_f8_data", 32'(data), 32'h200);
        wr(1, 12'h300, ADDR_B, CMD_WRITE);
        tick();
        chk("t3_pend_again", 32'(req_pending), 32'h2);
        chk("t3_inflight", 32'(data), 32'h200);
        settle(10, "t3_done");
        chk("t3_ack1", 32'(ack_cnt[1]), 3);
        chk("t3_ack2", 32'(ack_cnt[2]), 2);
        chk("t3_terr", 32'(timeout_err), 0);

        // 4: timeout
        model_en = 1'b0;
        wr(3, 12'h0BB, ADDR_D, CMD_WRITE_UPDATE);
        tick();
        wait_trig(1'b1, "t4_start");
        wr(1, 12'h0AA, ADDR_B, CMD_WRITE_UPDATE);
        hi = 0;
        while (dactrig && hi < 200) begin
            hi++;
            tick();
        end
        chk("t4_hi_cycles", 32'(hi), 32'(TO));
        chk("t4_terr", 32'(timeout_err), 1);
        chk("t4_no_ack", 32'(req_ack), 0);
        model_en = 1'b1;
        settle(12, "t4_done");
        chk("t4_ack1", 32'(ack_cnt[1]), 4);
        chk("t4_ack3", 32'(ack_cnt[3]), 2);
        chk("t4_terr_sticky", 32'(timeout_err), 1);

        // 5: async reset mid-frame
        wr(0, 12'h555, ADDR_A, CMD_WRITE);
        tick();
        wait_trig(1'b1, "t5_start");
        wr(2, 12'h777, ADDR_C, CMD_WRITE);
        tick();
        repeat (9) tick();
        chk("t5_pre_pend", 32'(req_pending), 32'h4);
        rst = 1'b1;
        #1;
        chk("t5_trig", 32'(dactrig), 0);
        chk("t5_fields", 32'({command, address, data}), 0);
        chk("t5_pend_ack", 32'({req_pending, req_ack}), 0);
        chk("t5_terr", 32'(timeout_err), 0);
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("t5_no_frame", 32'(frames.size()), 13);
        chk("t5_idle", 32'({dactrig, req_pending}), 0);

        // 6: stray dacdone in IDLE, then a normal frame
        stray = 1'b1;
        tick();
        chk("t6_no_ack", 32'(req_ack), 0);
        chk("t6_trig", 32'(dactrig), 0);
        tick();
        chk("t6_quiet", 32'({req_ack, dactrig, timeout_err}), 0);
        wr(1, 12'h0CD, ADDR_B, CMD_PWRDN);
        tick();
        chk("t6_pend", 32'(req_pending), 32'h2);
        chk("t6_trig_lo", 32'(dactrig), 0);
        tick();
        chk("t6_trig_hi", 32'(dactrig), 1);
        chk("t6_fields", 32'({command, address, data}), 32'h410CD);
        settle(14, "t6_done");

        // totals
        chk("n_frames", 32'(frames.size()), 14);
        for (int k = 0; k < 14; k++)
            if (k < frames.size()) chk($sformatf("frame%0d", k), 32'(frames[k]), 32'(exp_frames[k]));
        chk("ack0", 32'(ack_cnt[0]), 3);
        chk("ack1", 32'(ack_cnt[1]), 5);
        chk("ack2", 32'(ack_cnt[2]), 2);
        chk("ack3", 32'(ack_cnt[3]), 2);
        chk("min_gap", 32'(min_gap), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
